cic_interp_x64: RTL and testbench

//  Final 64x CIC interpolator of the 128x DAC interpolation chain. Sits directly

---
 rtl/cic_interp_x64.sv | 120 ++++++++++++
 tb/tb_cic_interp_x64.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_x64.sv
// Final 64x CIC interpolator (3 comb / 3 integrator stages) of the DAC interpolation chain,
// with a monitor that flags in_en strobes arriving off the expected R-clock cadence.
module cic_interp_x64 #(
  parameter int DW    = 16,
  parameter int R     = 64,
  parameter int N     = 3,
  parameter int ACC_W = 28,
  localparam int PW   = $clog2(R)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_en,
  input  logic signed [DW-1:0] data_in,
  input  logic                 err_clr,
  output logic signed [DW-1:0] data_out,
  output logic                 out_valid,
  output logic [PW-1:0]        phase,
  output logic                 rate_err
);

  localparam int SH = ACC_W - DW;
  localparam logic [PW-1:0]          PH_LAST = PW'(R - 1);
  localparam logic [PW-1:0]          PH_ONE  = PW'(1);
  localparam logic signed [ACC_W:0]  HALF    = (ACC_W + 1)'(2 ** (SH - 1));
  localparam logic signed [DW-1:0]   SAT_HI  = {1'b0, {(DW - 1){1'b1}}};
  localparam logic signed [DW-1:0]   SAT_LO  = {1'b1, {(DW - 1){1'b0}}};

  logic signed [ACC_W-1:0] comb_s   [N+1];
  logic signed [ACC_W-1:0] comb_d_r [N];
  logic signed [ACC_W-1:0] comb_out_r;
  logic                    stuff_v_r;
  logic signed [ACC_W-1:0] stuff_in_s;
  logic signed [ACC_W-1:0] integ_r  [N];
  logic signed [ACC_W:0]   round_s;
  logic signed [DW:0]      shift_s;
  logic signed [DW-1:0]    sat_s;
  logic [N:0]              prime_r;
  logic                    set_err_s;

  // Comb chain, zero-stuff select, round/saturate and rate-check decode
  always_comb begin
    comb_s[0] = {{(ACC_W - DW){data_in[DW-1]}}, data_in};
    for (int k = 1; k <= N; k++) begin
      comb_s[k] = comb_s[k-1] - comb_d_r[k-1];
    end
    if (stuff_v_r) begin
      stuff_in_s = comb_out_r;
    end else begin
      stuff_in_s = {ACC_W{1'b0}};
    end
    // One extra bit so the rounding offset cannot wrap before saturation
    round_s = {integ_r[N-1][ACC_W-1], integ_r[N-1]} + HALF;
    shift_s = round_s[ACC_W:SH];
    if (shift_s[DW] != shift_s[DW-1]) begin
      sat_s = shift_s[DW] ? SAT_LO : SAT_HI;
    end else begin
      sat_s = shift_s[DW-1:0];
    end
    if (!prime_r[0]) begin
      set_err_s = 1'b0;
    end else if (in_en) begin
      set_err_s = (phase != PH_LAST);
    end else begin
      set_err_s = (phase == PH_LAST);
    end
  end

  // Comb delays and comb output, advanced only on input strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) comb_d_r[k] <= {ACC_W{1'b0}};
      comb_out_r <= {ACC_W{1'b0}};
    end else if (in_en) begin
      for (int k = 0; k < N; k++) comb_d_r[k] <= comb_s[k];
      comb_out_r <= comb_s[N];
    end else begin
      comb_out_r <= comb_out_r;
    end
  end

  // Integrators run every clock and wrap modulo 2^ACC_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuff_v_r <= 1'b0;
      for (int k = 0; k < N; k++) integ_r[k] <= {ACC_W{1'b0}};
      data_out  <= {DW{1'b0}};
    end else begin
      stuff_v_r  <= in_en;
      integ_r[0] <= integ_r[0] + stuff_in_s;
      for (int k = 1; k < N; k++) integ_r[k] <= integ_r[k] + integ_r[k-1];
      data_out   <= sat_s;
    end
  end

  // Phase counter, priming shift register and sticky rate error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= {PW{1'b0}};
      prime_r   <= {(N + 1){1'b0}};
      out_valid <= 1'b0;
      rate_err  <= 1'b0;
    end else begin
      if (in_en || phase == PH_LAST) begin
        phase <= {PW{1'b0}};
      end else begin
        phase <= phase + PH_ONE;
      end
      prime_r   <= {prime_r[N-1:0], prime_r[0] | in_en};
      out_valid <= prime_r[N];
      if (set_err_s) begin
        rate_err <= 1'b1;
      end else if (err_clr) begin
        rate_err <= 1'b0;
      end else begin
        rate_err <= rate_err;
      end
    end
  end

endmodule

// File: tb/tb_cic_interp_x64.sv
// Directed bench for cic_interp_x64: impulse, DC, extremes, rate errors, mid-stream reset
// and alternating input against an independent convolution model.
module tb_cic_interp_x64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_en = 1'b0;
  logic signed [15:0] data_in = 16'sd0;
  logic               err_clr = 1'b0;
  logic signed [15:0] data_out;
  logic               out_valid;
  logic [5:0]         phase;
  logic               rate_err;

  int total = 0;
  int bad = 0;
  int h1 [64];
  int h2 [127];
  int h3 [190];

  cic_interp_x64 dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .data_in(data_in), .err_clr(err_clr),
    .data_out(data_out), .out_valid(out_valid), .phase(phase), .rate_err(rate_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later
  task automatic cyc(input logic en, input int d, input logic clr);
    in_en   = en;
    data_in = en ? 16'(d) : 16'sh5A5A;
    err_clr = clr;
    @(posedge clk);
    #1;
    in_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    in_en = 1'b0;
    err_clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int alt_x(input int k);
    return (k % 2 == 0) ? 16384 : -16384;
  endfunction

  // Direct-form reference: upsampled input convolved with the sinc^3 kernel
  function automatic int model_alt(input int n);
    int v = 0;
    int r;
    for (int k = 0; k <= n / 64; k++) begin
      if (n - 64 * k < 190) v += alt_x(k) * h3[n - 64 * k];
    end
    r = (v + 2048) >>> 12;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  initial begin
    int sum;
    int nz;
    int errs;
    int maxabs;
    int v;

    for (int i = 0; i < 64; i++) h1[i] = 1;
    for (int n = 0; n < 127; n++) begin
      h2[n] = 0;
      for (int j = 0; j < 64; j++) if (n - j >= 0 && n - j < 64) h2[n] += h1[j] * h1[n - j];
    end
    for (int n = 0; n < 190; n++) begin
      h3[n] = 0;
      for (int j = 0; j < 64; j++) if (n - j >= 0 && n - j < 127) h3[n] += h1[j] * h2[n - j];
    end

    // Reset state
    do_reset();
    check_val("rst_data", int'(data_out), 0);
    check_val("rst_valid", int'(out_valid), 0);
    check_val("rst_phase", int'(phase), 0);
    check_val("rst_err", int'(rate_err), 0);

    // T1 impulse
    sum = 0;
    nz = 0;
    for (int c = 0; c < 320; c++) begin
      cyc(c % 64 == 0, (c == 0) ? 4096 : 0, 1'b0);
      sum += int'(data_out);
      if (data_out != 16'sd0) nz++;
      if (c == 3) check_val("imp_valid_t3", int'(out_valid), 0);
      if (c == 3) check_val("imp_t3", int'(data_out), 0);
      if (c == 4) check_val("imp_valid_t4", int'(out_valid), 1);
      if (c == 4) check_val("imp_t4", int'(data_out), 1);
      if (c == 4) check_val("imp_phase4", int'(phase), 4);
      if (c == 5) check_val("imp_t5", int'(data_out), 3);
      if (c == 6) check_val("imp_t6", int'(data_out), 6);
      if (c == 7) check_val("imp_t7", int'(data_out), 10);
      if (c == 63) check_val("imp_phase63", int'(phase), 63);
      if (c == 64) check_val("imp_phase0", int'(phase), 0);
      if (c == 67) check_val("imp_t67", int'(data_out), 2080);
    end
    check_val("imp_sum", sum, 262144);
    check_val("imp_len", nz, 190);
    check_val("imp_err", int'(rate_err), 0);

    // T2 DC then T5 mid-stream reset
    do_reset();
    for (int c = 0; c < 310; c++) begin
      cyc(c % 64 == 0, 1000, 1'b0);
      if (c == 196) check_val("dc_196", int'(data_out), 1000);
      if (c == 300) check_val("dc_300", int'(data_out), 1000);
    end
    check_val("dc_err", int'(rate_err), 0);
    rst_n = 1'b0;
    #1;
    check_val("mrst_data", int'(data_out), 0);
    check_val("mrst_valid", int'(out_valid), 0);
    check_val("mrst_phase", int'(phase), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) cyc(1'b0, 0, 1'b0);
    check_val("mrst_noerr", int'(rate_err), 0);
    for (int c = 0; c < 8; c++) begin
      cyc(c == 0, 1000, 1'b0);
      if (c == 3) check_val("mrst_valid_t3", int'(out_valid), 0);
      if (c == 4) check_val("mrst_valid_t4", int'(out_valid), 1);
      if (c == 4) check_val("mrst_t4", int'(data_out), 0);
      if (c == 5) check_val("mrst_t5", int'(data_out), 1);
      if (c == 7) check_val("mrst_t7", int'(data_out), 2);
    end

    // T3 extremes, held for 40 input periods each
    do_reset();
    errs = 0;
    for (int c = 0; c < 2560; c++) begin
      cyc(c % 64 == 0, 32767, 1'b0);
      if (c >= 200 && data_out != 16'sd32767) errs++;
    end
    check_val("max_glitches", errs, 0);
    check_val("max_final", int'(data_out), 32767);
    errs = 0;
    for (int c = 0; c < 2560; c++) begin
      cyc(c % 64 == 0, -32768, 1'b0);
      if (c >= 200 && data_out != -16'sd32768) errs++;
    end
    check_val("min_glitches", errs, 0);
    check_val("min_final", int'(data_out), -32768);
    check_val("ext_err", int'(rate_err), 0);

    // T4 rate errors
    do_reset();
    for (int c = 0; c < 322; c++) begin
      cyc(c == 0 || c == 64 || c == 127 || c == 191 || c == 319 || c == 320, 0,
          c == 128 || c == 255 || c == 256);
      if (c == 126) check_val("early_before", int'(rate_err), 0);
      if (c == 127) check_val("early_set", int'(rate_err), 1);
      if (c == 128) check_val("clr", int'(rate_err), 0);
      if (c == 254) check_val("miss_before", int'(rate_err), 0);
      if (c == 255) check_val("miss_set_wins", int'(rate_err), 1);
      if (c == 255) check_val("miss_phase", int'(phase), 0);
      if (c == 256) check_val("clr2", int'(rate_err), 0);
      if (c == 319) check_val("ontime", int'(rate_err), 0);
      if (c == 320) check_val("back2back", int'(rate_err), 1);
    end

    // T6 alternating +/-16384 against the convolution model
    do_reset();
    errs = 0;
    maxabs = 0;
    for (int c = 0; c < 768; c++) begin
      cyc(c % 64 == 0, alt_x(c / 64), 1'b0);
      v = (c >= 4) ? model_alt(c - 4) : 0;
      if (int'(data_out) != v) begin
        if (errs == 0) $display("FAIL alt_first c=%0d: got %0d expected %0d", c, data_out, v);
        errs++;
      end
      if (c >= 300 && data_out > 16'sd0 && int'(data_out) > maxabs) maxabs = int'(data_out);
      if (c >= 300 && data_out < 16'sd0 && -int'(data_out) > maxabs) maxabs = -int'(data_out);
    end
    check_val("alt_model", errs, 0);
    check_val("alt_amp_low", int'(maxabs <= 8256), 1);
    check_val("alt_err", int'(rate_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
